// File: rtl/obj_ram_pkg.sv
// Shared definitions for the object RAM and its arbiter: sizes, requester IDs,
// owner encoding and the bit layout of a stone/gold/diamond record.
package obj_ram_pkg;

  localparam int ADDR_W      = 4;
  localparam int DATA_W      = 32;
  localparam int RP_MAX_WAIT = 64;
  localparam int RP_WAIT_W   = 7;

  localparam int REQ_LD = 0;
  localparam int REQ_DR = 1;
  localparam int REQ_RP = 2;

  typedef enum logic [1:0] {
    OWN_LD   = 2'd0,
    OWN_DR   = 2'd1,
    OWN_RP   = 2'd2,
    OWN_NONE = 2'd3
  } owner_e;

  // Object record layout
  localparam int OBJ_X_HI    = 31;
  localparam int OBJ_X_LO    = 23;
  localparam int OBJ_Y_HI    = 18;
  localparam int OBJ_Y_LO    = 11;
  localparam int OBJ_TYPE_HI = 3;
  localparam int OBJ_TYPE_LO = 2;
  localparam int OBJ_VIS_BIT = 1;
  localparam int OBJ_MOV_BIT = 0;

  function automatic logic [2:0] owner_onehot(owner_e o);
    logic [2:0] v;
    v = 3'b000;
    case (o)
      OWN_LD:  v[REQ_LD] = 1'b1;
      OWN_DR:  v[REQ_DR] = 1'b1;
      OWN_RP:  v[REQ_RP] = 1'b1;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/rope_wait_counter.sv
// Counts consecutive cycles the rope controller has waited; saturates and
// raises starved_o so the arbiter can let rope jump ahead of the draw engine.
module rope_wait_counter
  import obj_ram_pkg::*;
#(
  parameter int MAX_WAIT = RP_MAX_WAIT,
  parameter int WAIT_W   = RP_WAIT_W
) (
  input  logic clock,
  input  logic resetn,
  input  logic wait_i,
  input  logic clr_i,
  output logic starved_o
);

  logic [WAIT_W-1:0] count_q, count_d;
  logic              starved_q;

  always_comb begin
    count_d = count_q;
    if (clr_i || !wait_i)
      count_d = '0;
    else if (count_q != WAIT_W'(MAX_WAIT))
      count_d = count_q + WAIT_W'(1);
  end

  // Flag is computed from the next count so it always equals (count_q == MAX).
  always_ff @(posedge clock) begin
    if (!resetn) begin
      count_q   <= '0;
      starved_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      starved_q <= (count_d == WAIT_W'(MAX_WAIT));
    end
  end

  assign starved_o = starved_q;

endmodule

// File: rtl/object_ram_arbiter.sv
// One-access-per-cycle scheduler for the shared 16x32 object RAM: loader first,
// then starved rope, then draw, then rope when no draw burst holds the lock.
module object_ram_arbiter #(
  parameter int ADDR_W   = obj_ram_pkg::ADDR_W,
  parameter int DATA_W   = obj_ram_pkg::DATA_W,
  parameter int MAX_WAIT = obj_ram_pkg::RP_MAX_WAIT,
  parameter int WAIT_W   = obj_ram_pkg::RP_WAIT_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              ld_req,
  input  logic              dr_req,
  input  logic              rp_req,
  input  logic              ld_we,
  input  logic              dr_we,
  input  logic              rp_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [ADDR_W-1:0] dr_addr,
  input  logic [ADDR_W-1:0] rp_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic [DATA_W-1:0] dr_wdata,
  input  logic [DATA_W-1:0] rp_wdata,
  input  logic              dr_lock,
  output logic              ld_gnt,
  output logic              dr_gnt,
  output logic              rp_gnt,
  output logic              ld_rvalid,
  output logic              dr_rvalid,
  output logic              rp_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              rp_starved
);
  import obj_ram_pkg::*;

  owner_e            owner_d, owner_q;
  logic [2:0]        gnt_q, rvalid_q, elig;
  logic [ADDR_W-1:0] ram_addr_q, addr_d;
  logic [DATA_W-1:0] ram_wdata_q, wdata_d;
  logic              ram_wren_q, we_d;
  logic              starved;

  // A requester whose grant is showing this cycle sits out, so a held
  // request is not issued twice.
  assign elig = {rp_req, dr_req, ld_req} & ~gnt_q;

  always_comb begin
    owner_d = OWN_NONE;
    if (elig[REQ_LD])
      owner_d = OWN_LD;
    else if (elig[REQ_RP] && starved)
      owner_d = OWN_RP;
    else if (elig[REQ_DR])
      owner_d = OWN_DR;
    else if (elig[REQ_RP] && !dr_lock)
      owner_d = OWN_RP;
  end

  always_comb begin
    addr_d  = ram_addr_q;
    wdata_d = ram_wdata_q;
    we_d    = 1'b0;
    case (owner_d)
      OWN_LD: begin
        addr_d  = ld_addr;
        wdata_d = ld_wdata;
        we_d    = ld_we;
      end
      OWN_DR: begin
        addr_d  = dr_addr;
        wdata_d = dr_wdata;
        we_d    = dr_we;
      end
      OWN_RP: begin
        addr_d  = rp_addr;
        wdata_d = rp_wdata;
        we_d    = rp_we;
      end
      default: ;
    endcase
  end

  // owner_q tracks the access currently on the RAM bus; a read there turns
  // into an rvalid pulse one cycle later, when ram_q carries its data.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      owner_q     <= OWN_NONE;
      gnt_q       <= 3'b000;
      rvalid_q    <= 3'b000;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_wren_q  <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      gnt_q       <= owner_onehot(owner_d);
      rvalid_q    <= ram_wren_q ? 3'b000 : owner_onehot(owner_q);
      ram_addr_q  <= addr_d;
      ram_wdata_q <= wdata_d;
      ram_wren_q  <= we_d;
    end
  end

  rope_wait_counter #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_rope_wait (
    .clock     (clock),
    .resetn    (resetn),
    .wait_i    (rp_req),
    .clr_i     (gnt_q[REQ_RP]),
    .starved_o (starved)
  );

  assign ld_gnt     = gnt_q[REQ_LD];
  assign dr_gnt     = gnt_q[REQ_DR];
  assign rp_gnt     = gnt_q[REQ_RP];
  assign ld_rvalid  = rvalid_q[REQ_LD];
  assign dr_rvalid  = rvalid_q[REQ_DR];
  assign rp_rvalid  = rvalid_q[REQ_RP];
  assign rdata      = ram_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign ram_wren   = ram_wren_q;
  assign rp_starved = starved;

endmodule

// File: tb/tb_object_ram_arbiter.sv
// Bench for object_ram_arbiter: a write-first RAM model plus per-requester
// queues of expected read data, checked whenever an rvalid pulse appears.
module tb_object_ram_arbiter;

  localparam int AW = 4;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          resetn;
  logic          ld_req, dr_req, rp_req;
  logic          ld_we, dr_we, rp_we;
  logic [AW-1:0] ld_addr, dr_addr, rp_addr;
  logic [DW-1:0] ld_wdata, dr_wdata, rp_wdata;
  logic          dr_lock;
  logic          ld_gnt, dr_gnt, rp_gnt;
  logic          ld_rvalid, dr_rvalid, rp_rvalid;
  logic [DW-1:0] rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_wren;
  logic [DW-1:0] ram_q;
  logic          rp_starved;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] exp_ld [$];
  logic [DW-1:0] exp_dr [$];
  logic [DW-1:0] exp_rp [$];

  always #5 clock = ~clock;

  object_ram_arbiter dut (
    .clock      (clock),
    .resetn     (resetn),
    .ld_req     (ld_req),
    .dr_req     (dr_req),
    .rp_req     (rp_req),
    .ld_we      (ld_we),
    .dr_we      (dr_we),
    .rp_we      (rp_we),
    .ld_addr    (ld_addr),
    .dr_addr    (dr_addr),
    .rp_addr    (rp_addr),
    .ld_wdata   (ld_wdata),
    .dr_wdata   (dr_wdata),
    .rp_wdata   (rp_wdata),
    .dr_lock    (dr_lock),
    .ld_gnt     (ld_gnt),
    .dr_gnt     (dr_gnt),
    .rp_gnt     (rp_gnt),
    .ld_rvalid  (ld_rvalid),
    .dr_rvalid  (dr_rvalid),
    .rp_rvalid  (rp_rvalid),
    .rdata      (rdata),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_wren   (ram_wren),
    .ram_q      (ram_q),
    .rp_starved (rp_starved)
  );

  // Single-port write-first RAM, one cycle read latency
  logic [DW-1:0] mem [16];
  bit            mem_loaded = 1'b0;
  always @(posedge clock) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hC0DE_0000 + DW'(i);
      mem_loaded <= 1'b1;
      ram_q      <= '0;
    end else begin
      if (ram_wren) mem[ram_addr] <= ram_wdata;
      ram_q <= ram_wren ? ram_wdata : mem[ram_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%08h", tag, got);
    end
  endtask

  task automatic sb_check(input int id);
    int            n;
    logic [DW-1:0] e;
    case (id)
      0:       n = exp_ld.size();
      1:       n = exp_dr.size();
      default: n = exp_rp.size();
    endcase
    check_eq($sformatf("rvalid%0d_expected", id), 32'(n != 0), 32'd1);
    if (n != 0) begin
      case (id)
        0:       e = exp_ld.pop_front();
        1:       e = exp_dr.pop_front();
        default: e = exp_rp.pop_front();
      endcase
      check_eq($sformatf("rdata%0d", id), rdata, e);
    end
  endtask

  // Monitor: read data scoreboard and per-requester grant spacing
  logic [2:0] prev_gnt = 3'b000;
  always @(negedge clock) begin
    if (resetn === 1'b1) begin
      if (ld_rvalid) sb_check(0);
      if (dr_rvalid) sb_check(1);
      if (rp_rvalid) sb_check(2);
      if (ld_gnt) check_eq("gnt_spacing_ld", 32'(prev_gnt[0]), 32'd0);
      if (dr_gnt) check_eq("gnt_spacing_dr", 32'(prev_gnt[1]), 32'd0);
      if (rp_gnt) check_eq("gnt_spacing_rp", 32'(prev_gnt[2]), 32'd0);
      prev_gnt <= {rp_gnt, dr_gnt, ld_gnt};
    end else begin
      prev_gnt <= 3'b000;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] gnt_vec();
    return {29'd0, ld_gnt, dr_gnt, rp_gnt};
  endfunction

  function automatic logic [31:0] rv_vec();
    return {29'd0, ld_rvalid, dr_rvalid, rp_rvalid};
  endfunction

  initial begin
    int early_gnt;
    resetn  = 1'b0;
    ld_req  = 0; dr_req  = 0; rp_req  = 0;
    ld_we   = 0; dr_we   = 0; rp_we   = 0;
    ld_addr = 0; dr_addr = 0; rp_addr = 0;
    ld_wdata = 0; dr_wdata = 0; rp_wdata = 0;
    dr_lock = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'hC0DE_0000 + DW'(i);

    repeat (3) tick();
    check_eq("rst_gnt", gnt_vec(), 32'd0);
    check_eq("rst_rvalid", rv_vec(), 32'd0);
    check_eq("rst_wren", 32'(ram_wren), 32'd0);
    check_eq("rst_starved", 32'(rp_starved), 32'd0);
    check_eq("rst_addr", 32'(ram_addr), 32'd0);
    check_eq("rst_wdata", ram_wdata, 32'd0);
    resetn = 1'b1;
    tick();

    // Single rope read
    rp_req = 1; rp_we = 0; rp_addr = 4'd5;
    exp_rp.push_back(ref_mem[5]);
    tick();
    check_eq("single_gnt", gnt_vec(), 32'b001);
    check_eq("single_addr", 32'(ram_addr), 32'd5);
    check_eq("single_wren", 32'(ram_wren), 32'd0);
    rp_req = 0;
    tick();
    check_eq("single_rv", rv_vec(), 32'b001);
    check_eq("single_gnt_after", gnt_vec(), 32'd0);
    tick();

    // All three at once: ld write, dr read, rp read
    ld_req = 1; ld_we = 1; ld_addr = 4'd2; ld_wdata = 32'hA5A5_0002;
    ref_mem[2] = 32'hA5A5_0002;
    dr_req = 1; dr_we = 0; dr_addr = 4'd3; exp_dr.push_back(ref_mem[3]);
    rp_req = 1; rp_we = 0; rp_addr = 4'd4; exp_rp.push_back(ref_mem[4]);
    tick();
    check_eq("all3_t1_gnt", gnt_vec(), 32'b100);
    check_eq("all3_t1_wren", 32'(ram_wren), 32'd1);
    check_eq("all3_t1_addr", 32'(ram_addr), 32'd2);
    check_eq("all3_t1_wdata", ram_wdata, 32'hA5A5_0002);
    ld_req = 0;
    tick();
    check_eq("all3_t2_gnt", gnt_vec(), 32'b010);
    check_eq("all3_t2_addr", 32'(ram_addr), 32'd3);
    check_eq("all3_t2_rv", rv_vec(), 32'd0);
    dr_req = 0;
    tick();
    check_eq("all3_t3_gnt", gnt_vec(), 32'b001);
    check_eq("all3_t3_rv", rv_vec(), 32'b010);
    rp_req = 0;
    tick();
    check_eq("all3_t4_rv", rv_vec(), 32'b001);
    check_eq("all3_t4_gnt", gnt_vec(), 32'd0);
    tick();

    // Write then read same address
    ld_req = 1; ld_we = 1; ld_addr = 4'd7; ld_wdata = 32'h1234_5678;
    ref_mem[7] = 32'h1234_5678;
    tick();
    check_eq("wr_rd_ld_gnt", gnt_vec(), 32'b100);
    ld_req = 0;
    dr_req = 1; dr_we = 0; dr_addr = 4'd7; exp_dr.push_back(ref_mem[7]);
    tick();
    check_eq("wr_rd_dr_gnt", gnt_vec(), 32'b010);
    dr_req = 0;
    tick();
    check_eq("wr_rd_rv", rv_vec(), 32'b010);
    tick();

    // Draw lock with continuous draw writes; rope must wait for starvation
    dr_lock = 1;
    dr_req = 1; dr_we = 1; dr_addr = 4'd9; dr_wdata = 32'hDEAD_0009;
    ref_mem[9] = 32'hDEAD_0009;
    rp_req = 1; rp_we = 0; rp_addr = 4'd6; exp_rp.push_back(ref_mem[6]);
    early_gnt = 0;
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (rp_gnt) early_gnt++;
      if (k == 63) check_eq("starve_t63", 32'(rp_starved), 32'd0);
      if (k == 64) check_eq("starve_t64", 32'(rp_starved), 32'd1);
    end
    tick();
    check_eq("starve_no_early_gnt", 32'(early_gnt), 32'd0);
    check_eq("starve_t65_rp_gnt", 32'(rp_gnt), 32'd1);
    rp_req = 0;
    tick();
    check_eq("starve_t66_cleared", 32'(rp_starved), 32'd0);
    dr_req = 0; dr_lock = 0;
    repeat (2) tick();

    // Held rope request: grants every other cycle only
    rp_req = 1; rp_we = 0; rp_addr = 4'd8;
    exp_rp.push_back(ref_mem[8]);
    exp_rp.push_back(ref_mem[8]);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_eq($sformatf("held_gnt_t%0d", k), 32'(rp_gnt), 32'(k == 1 || k == 3));
      if (k == 4) rp_req = 0;
    end
    repeat (3) tick();

    // Reset during the grant cycle of a read
    rp_req = 1; rp_we = 0; rp_addr = 4'd10;
    tick();
    check_eq("rstmid_gnt", 32'(rp_gnt), 32'd1);
    resetn = 1'b0;
    rp_req = 0;
    tick();
    check_eq("rstmid_rv", rv_vec(), 32'd0);
    check_eq("rstmid_gnt_after", gnt_vec(), 32'd0);
    check_eq("rstmid_wren", 32'(ram_wren), 32'd0);
    check_eq("rstmid_addr", 32'(ram_addr), 32'd0);
    check_eq("rstmid_wdata", ram_wdata, 32'd0);
    check_eq("rstmid_starved", 32'(rp_starved), 32'd0);
    resetn = 1'b1;
    repeat (3) tick();

    check_eq("sb_drained", 32'(exp_ld.size() + exp_dr.size() + exp_rp.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
